// File: rtl/val2_seq_shifter.sv
// -----------------------------------------------------------------------------
// val2_seq_shifter
//
// Multi-cycle operand-2 sequencer for the EXE stage. It decodes the ARM
// shifter operand, then applies one single-bit shift or rotate per cycle.
// This gives register-specified shift amounts (taken from Rs) and
// architectural carry-out semantics. While the unit is working, busy is held
// high so that the hazard unit stalls the pipeline until done.
//
// Ports:
//   clk            : system clock, rising edge
//   rst            : synchronous active-high reset
//   start          : request, sampled only in IDLE (hold until done)
//   val_rm         : Rm value to be shifted
//   val_rs         : Rs value, bits [7:0] give the register-shift amount
//   shift_operand  : instruction bits [11:0]
//   immediate      : I bit
//   is_mem_command : LDR/STR offset mode
//   carry_in       : current CPSR C flag
//   busy           : high whenever the sequencer is not IDLE
//   done           : one-cycle pulse, result valid in that cycle
//   val2_out       : operand 2, held until the next accepted start
//   carry_out      : shifter carry, held with val2_out
// -----------------------------------------------------------------------------
module val2_seq_shifter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] val_rm,
  input  logic [WIDTH-1:0] val_rs,
  input  logic [11:0]      shift_operand,
  input  logic             immediate,
  input  logic             is_mem_command,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] val2_out,
  output logic             carry_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_LSL = 2'd0,
    OP_LSR = 2'd1,
    OP_ASR = 2'd2,
    OP_ROR = 2'd3
  } shop_t;

  state_t           state_q, state_d;
  shop_t            op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] val2_q, val2_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] dec_acc_s;
  shop_t            dec_op_s;
  logic [5:0]       dec_amt_s;
  logic [7:0]       rs_amt_s;
  logic [WIDTH-1:0] step_acc_s;
  logic             step_carry_s;

  assign rs_amt_s = val_rs[7:0];

  // Decode the shifter operand into start value, operation and step count.
  always_comb begin
    dec_acc_s = val_rm;
    dec_op_s  = OP_LSL;
    dec_amt_s = 6'd0;
    if (is_mem_command) begin
      dec_acc_s = {{(WIDTH-12){1'b0}}, shift_operand};
      dec_op_s  = OP_LSL;
      dec_amt_s = 6'd0;
    end else if (immediate) begin
      dec_acc_s = {{(WIDTH-8){1'b0}}, shift_operand[7:0]};
      dec_op_s  = OP_ROR;
      dec_amt_s = {1'b0, shift_operand[11:8], 1'b0};
    end else if (!shift_operand[4]) begin
      // Immediate shift: amount 0 is a plain pass-through for every op.
      dec_acc_s = val_rm;
      dec_op_s  = shop_t'(shift_operand[6:5]);
      dec_amt_s = {1'b0, shift_operand[11:7]};
    end else begin
      dec_acc_s = val_rm;
      dec_op_s  = shop_t'(shift_operand[6:5]);
      if (shop_t'(shift_operand[6:5]) == OP_ROR) begin
        // A nonzero multiple of 32 rotates a full turn so C picks up bit 31.
        if (rs_amt_s == 8'd0) begin
          dec_amt_s = 6'd0;
        end else if (val_rs[4:0] != 5'd0) begin
          dec_amt_s = {1'b0, val_rs[4:0]};
        end else begin
          dec_amt_s = 6'd32;
        end
      end else begin
        // 33 single steps already give the architectural result for any
        // larger amount, so longer shifts are clamped.
        if (rs_amt_s > 8'd33) begin
          dec_amt_s = 6'd33;
        end else begin
          dec_amt_s = rs_amt_s[5:0];
        end
      end
    end
  end

  // One single-bit step of the latched operation.
  always_comb begin
    step_acc_s   = acc_q;
    step_carry_s = carry_q;
    case (op_q)
      OP_LSL: begin
        step_carry_s = acc_q[WIDTH-1];
        step_acc_s   = {acc_q[WIDTH-2:0], 1'b0};
      end
      OP_LSR: begin
        step_carry_s = acc_q[0];
        step_acc_s   = {1'b0, acc_q[WIDTH-1:1]};
      end
      OP_ASR: begin
        step_carry_s = acc_q[0];
        step_acc_s   = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      end
      OP_ROR: begin
        step_carry_s = acc_q[0];
        step_acc_s   = {acc_q[0], acc_q[WIDTH-1:1]};
      end
      default: begin
        step_carry_s = carry_q;
        step_acc_s   = acc_q;
      end
    endcase
  end

  // Next-state logic for the sequencer and its registered outputs.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    val2_d  = val2_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = dec_acc_s;
          op_d    = dec_op_s;
          cnt_d   = dec_amt_s;
          carry_d = carry_in;
          if (dec_amt_s == 6'd0) begin
            state_d = ST_DONE;
            val2_d  = dec_acc_s;
            cout_d  = carry_in;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        acc_d   = step_acc_s;
        carry_d = step_carry_s;
        cnt_d   = cnt_q - 6'd1;
        // Results are registered on the edge that performs the last step.
        if (cnt_q <= 6'd1) begin
          state_d = ST_DONE;
          cnt_d   = 6'd0;
          val2_d  = step_acc_s;
          cout_d  = step_carry_s;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LSL;
      acc_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cnt_q   <= 6'd0;
      val2_q  <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      val2_q  <= val2_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign val2_out  = val2_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_val2_seq_shifter.sv
module tb_val2_seq_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] val_rm;
  logic [31:0] val_rs;
  logic [11:0] shift_operand;
  logic        immediate;
  logic        is_mem_command;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [31:0] val2_out;
  logic        carry_out;

  int compared = 0;
  int mismatched = 0;

  val2_seq_shifter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .val_rm(val_rm), .val_rs(val_rs),
    .shift_operand(shift_operand), .immediate(immediate),
    .is_mem_command(is_mem_command), .carry_in(carry_in), .busy(busy),
    .done(done), .val2_out(val2_out), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural reference: result of the whole shift computed in one go.
  task automatic model(input logic [31:0] rm, input logic [31:0] rs, input logic [11:0] so,
                       input logic imm, input logic mem, input logic cin,
                       output int amt, output logic [31:0] v, output logic c);
    int op;
    int s;
    logic [31:0] base;
    logic [63:0] x;
    op = 0;
    base = rm;
    if (mem) begin
      base = {20'd0, so};
      amt = 0;
    end else if (imm) begin
      base = {24'd0, so[7:0]};
      op = 3;
      amt = int'(so[11:8]) * 2;
    end else if (!so[4]) begin
      op = int'(so[6:5]);
      amt = int'(so[11:7]);
    end else begin
      op = int'(so[6:5]);
      s = int'(rs[7:0]);
      if (op != 3) amt = (s > 33) ? 33 : s;
      else if (s == 0) amt = 0;
      else if (rs[4:0] != 5'd0) amt = int'(rs[4:0]);
      else amt = 32;
    end
    if (amt == 0) begin
      v = base;
      c = cin;
    end else begin
      case (op)
        0: begin x = {32'd0, base} << amt; v = x[31:0]; c = x[32]; end
        1: begin x = {base, 32'd0} >> amt; v = x[63:32]; c = x[31]; end
        2: begin x = $signed({base, 32'd0}) >>> amt; v = x[63:32]; c = x[31]; end
        default: begin v = (base >> amt) | (base << (32 - amt)); c = v[31]; end
      endcase
    end
  endtask

  // Runs one operation from a negedge; inputs are scrambled after accept.
  task automatic run_op(input string tag, input logic [31:0] rm, input logic [31:0] rs,
                        input logic [11:0] so, input logic imm, input logic mem, input logic cin);
    int amt;
    int cycles;
    logic [31:0] ev;
    logic ec;
    logic got;
    logic bad_busy;
    model(rm, rs, so, imm, mem, cin, amt, ev, ec);
    val_rm = rm; val_rs = rs; shift_operand = so;
    immediate = imm; is_mem_command = mem; carry_in = cin;
    start = 1'b1;
    @(posedge clk);
    #1;
    val_rm = $urandom; val_rs = $urandom; shift_operand = 12'($urandom);
    carry_in = 1'($urandom); immediate = 1'($urandom); is_mem_command = 1'($urandom);
    cycles = 0; got = 1'b0; bad_busy = 1'b0;
    while (!got && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (!busy) bad_busy = 1'b1;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check({tag, " done seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, cycles, amt + 1);
    check({tag, " busy"}, 32'(bad_busy), 32'd0);
    check({tag, " val2"}, val2_out, ev);
    check({tag, " carry"}, 32'(carry_out), 32'(ec));
    @(negedge clk);
    check({tag, " done pulse"}, {30'd0, busy, done}, 32'd0);
    check({tag, " held"}, val2_out, ev);
  endtask

  initial begin
    int sel;
    int dones;
    logic [31:0] rs;
    rst = 1'b1; start = 1'b0; val_rm = 32'd0; val_rs = 32'd0; shift_operand = 12'd0;
    immediate = 1'b0; is_mem_command = 1'b0; carry_in = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", {val2_out[30:0], busy, done, carry_out} | {val2_out[31], 31'd0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mem", 32'hDEADBEEF, 32'd5, 12'hABC, 1'b0, 1'b1, 1'b1);
    run_op("mem_imm_prio", 32'h1, 32'd5, 12'h4FF, 1'b1, 1'b1, 1'b0);
    run_op("imm_ror", 32'h0, 32'h0, 12'h4FF, 1'b1, 1'b0, 1'b0);
    run_op("imm_asr", 32'h80000008, 32'h0, 12'h240, 1'b0, 1'b0, 1'b0);
    run_op("imm_lsr0", 32'h80000008, 32'h0, 12'h020, 1'b0, 1'b0, 1'b1);
    run_op("reg_lsl40", 32'h80000001, 32'd40, 12'h010, 1'b0, 1'b0, 1'b1);
    run_op("reg_lsl32", 32'h80000001, 32'd32, 12'h010, 1'b0, 1'b0, 1'b0);
    run_op("reg_lsr32", 32'h80000001, 32'd32, 12'h030, 1'b0, 1'b0, 1'b0);
    run_op("reg_asr255", 32'h80000001, 32'hFF, 12'h050, 1'b0, 1'b0, 1'b0);
    run_op("reg_ror32", 32'h80001234, 32'h20, 12'h070, 1'b0, 1'b0, 1'b0);
    run_op("reg_ror0", 32'h80001234, 32'h100, 12'h070, 1'b0, 1'b0, 1'b1);
    run_op("reg_ror_x45", 32'h80001234, 32'h45, 12'h070, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 4);
      rs = $urandom;
      case (sel)
        0: rs[7:0] = 8'd0;
        1: rs[7:0] = 8'd32;
        2: rs[7:0] = 8'd33;
        3: rs[7:0] = 8'($urandom_range(0, 40));
        default: rs = $urandom;
      endcase
      sel = $urandom_range(0, 3);
      run_op("rand", $urandom, rs, 12'($urandom) | (sel == 3 ? 12'h010 : 12'h000)
                                    & (sel == 2 ? 12'hFEF : 12'hFFF),
             1'(sel == 1), 1'(sel == 0), 1'($urandom));
    end

    // Extra start pulse while shifting must be ignored.
    val_rm = 32'h80000001; val_rs = 32'd40; shift_operand = 12'h010;
    immediate = 1'b0; is_mem_command = 1'b0; carry_in = 1'b1;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("ignored start dones", dones, 1);
    check("ignored start val2", {val2_out[31:1], carry_out}, 32'd0);
    check("ignored start idle", 32'(busy), 32'd0);

    // Reset in the middle of a shift aborts without done.
    val_rm = 32'h12345678; val_rs = 32'd40; shift_operand = 12'h050;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy/done", {30'd0, busy, done}, 32'd0);
    check("abort val2", val2_out, 32'd0);
    check("abort carry", 32'(carry_out), 32'd0);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("abort no done", dones, 0);

    run_op("after_reset", 32'h0000F00F, 32'd4, 12'h030, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/val2_seq_shifter.md
Name: val2_seq_shifter

Overview:
- Multi-cycle sequencer that produces operand 2 (Val2) and the shifter carry-out for the EXE stage.
- Adds register-specified shifts (shift amount taken from Rs) and real ARM carry semantics, both absent from the combinational operand-2 path.
- Performs one single-bit shift or rotate per cycle under an FSM. Asserts `busy` so the hazard unit stalls the pipeline until `done`.
- Sits between the ID/EXE register and the ALU operand-2 mux.

Parameters:
- `WIDTH`, 32, datapath width; equals `REGISTER_LEN`.

Ports:
- `clk` input 1: system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE.
- `val_rm` input WIDTH: Rm value to be shifted.
- `val_rs` input WIDTH: Rs value; bits [7:0] give the register-shift amount.
- `shift_operand` input 12: instruction bits [11:0].
- `immediate` input 1: I bit.
- `is_mem_command` input 1: LDR/STR offset mode.
- `carry_in` input 1: current CPSR C flag.
- `busy` output 1: high while not IDLE; drives pipeline stall.
- `done` output 1: one-cycle pulse; result valid in that cycle.
- `val2_out` output WIDTH: operand 2; held until the next accepted start.
- `carry_out` output 1: shifter carry; held with `val2_out`.

Behaviour:
- Reset (the cycle after `rst` is sampled high): state=IDLE, `busy`=0, `done`=0, `val2_out`=0, `carry_out`=0, counter=0.
- `rst` overrides everything, including an operation in flight. An aborted operation never produces `done`.
- States:
  - IDLE.
  - SHIFT.
  - DONE. DONE always lasts exactly one cycle, then returns to IDLE.
- Accept: at an edge where state=IDLE and `start`=1, latch the inputs and decode. Go to SHIFT if amt>0, else go to DONE.
- `start` in SHIFT or DONE is ignored (not queued). The requester must hold `start` until it sees `done`.
- Decode, in priority order:
  1. `is_mem_command`=1: acc = zero-extended `shift_operand`[11:0]; amt=0; carry = `carry_in`.
  2. `immediate`=1: acc = zero-extended `shift_operand`[7:0]; op=ROR; amt = 2×`shift_operand`[11:8] (0..30).
  3. `shift_operand`[4]=0 (immediate shift): op = `shift_operand`[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR); amt = `shift_operand`[11:7].
     - Amount 0 means no shift for every op. This matches the existing combinational path; there is no RRX and no LSR/ASR #32 encoding.
  4. `shift_operand`[4]=1 (register shift): op = `shift_operand`[6:5]; s = `val_rs`[7:0].
     - LSL/LSR/ASR: amt = min(s, 33).
     - ROR: amt = `val_rs`[4:0] if that is nonzero. If `val_rs`[4:0]=0 and s≠0, amt=32. If s=0, amt=0.
- SHIFT, each edge: acc is shifted or rotated by exactly 1 bit; carry_reg captures the bit shifted out; counter is decremented. When counter reaches 0, go to DONE.
  - LSL: carry = acc[WIDTH-1]; fill with 0.
  - LSR: carry = acc[0]; fill with 0.
  - ASR: carry = acc[0]; fill with acc[WIDTH-1].
  - ROR: carry = acc[0]; acc[WIDTH-1] = acc[0].
- Clamping the register-shift amount to 33 single steps yields the architectural results directly:
  - LSL 32 gives 0 with C = rm[0].
  - LSL/LSR by more than 32 gives 0 with C=0.
  - ASR of 32 or more gives all sign bits with C = rm[31].
  - ROR 32 gives rm with C = rm[31].
- Carry when amt=0: `carry_out` = `carry_in`.
- DONE: `val2_out`=acc, `carry_out`=carry_reg, `done`=1, `busy`=1. The outputs are registered at the edge entering DONE and hold after DONE.
- Latency: if `start` is accepted at edge t, `done` is high in the cycle after edge t+amt.
  - Minimum: 1 cycle (mem command, or amt=0).
  - Maximum: 34 cycles (register shift by ≥33).
- Counter is 6 bits. amt is never greater than 33, so no wrap.
- `busy` is low only in IDLE. Back-to-back operation: the earliest next accept is the edge after DONE.

Test Plan:
- Mem command: `shift_operand`=12'hABC, `is_mem_command`=1, start → `done` 1 cycle later; `val2_out`=32'h00000ABC; `carry_out`=`carry_in`.
- Immediate rotate: `immediate`=1, `shift_operand`=12'h4FF → amt 8; `done` 9 cycles after start; `val2_out`=32'hFF000000; `carry_out`=1.
- Immediate ASR: `val_rm`=32'h80000008, `shift_operand`=12'h240 (#4, ASR) → `val2_out`=32'hF8000000, `carry_out`=1, latency 5.
- Register LSL: `val_rm`=32'h80000001, `val_rs`=40, `shift_operand`=12'h010 → `val2_out`=0, `carry_out`=0, `done` after 34 cycles. With `val_rs`=32 → `val2_out`=0, `carry_out`=1.
- Register ROR: `val_rs`=32'h20, `val_rm`=32'h8000_1234, `shift_operand`=12'h070 → `val2_out`=`val_rm`, `carry_out`=1. With `val_rs`=0 → `val2_out`=`val_rm`, `carry_out`=`carry_in`, latency 1.
- Control: pulse `start` again mid-SHIFT → ignored, single `done`. Assert `rst` mid-SHIFT → next cycle IDLE with all outputs 0 and no `done`.
